rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-way round-robin arbiter that shares a single 3-bit-addressed resource between eight requesters. It emits a registered grant index plus its one-hot decode, the same 3-to-8 mapping used by the select decoders in this design. Each grant has a bounded hold time. The block sits in front of the shared resource select path and sequences which requester owns it on each cycle.

## Interface
- HOLD_MAX, 16, maximum consecutive cycles a grant may be held; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  8  request vector; req[i] stays high while requester i wants or uses the resource.
- gnt  output  8  one-hot grant; all zeros when nothing is granted.
- gnt_idx  output  3  binary index of current grant; 0 when idle.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- All outputs are registered. The relation gnt == (gnt_valid ? 1<<gnt_idx : 0) holds in every cycle.
- State machine:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1.
- Rotating priority pointer ptr[2:0]. The requester searched first is ptr, then ptr+1, and so on, with the search wrapping modulo 8.
- IDLE, any req bit high at an edge: select the first set req bit at or after ptr, load gnt_idx, clear hold counter, go to GRANT.
- IDLE, req==0: stay in IDLE.
- GRANT, req[gnt_idx]==0 at an edge (normal release):
  - go to IDLE;
  - ptr <= gnt_idx+1 (mod 8);
  - gnt, gnt_idx and gnt_valid clear.
- GRANT, req[gnt_idx]==1 and hold counter == HOLD_MAX-1 (forced release):
  - go to IDLE;
  - ptr <= gnt_idx+1;
  - timeout <= 1 for exactly one cycle.
- GRANT otherwise: hold counter increments and the grant is held unchanged. Changes on other req bits are ignored while in GRANT.
- Hold counter is 8 bits wide and never wraps, because the forced release occurs first.
- A revoked requester that keeps req high re-competes in the next IDLE arbitration. The advanced pointer places it last among current requesters.
- Reset values: state IDLE, ptr=0, hold counter=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0.
- Reset has priority over every transition, including mid-grant and in the timeout cycle. Outputs reach their reset values at the edge where rst_n is sampled low.

## Timing
- Arbitration latency: req sampled at edge k puts gnt valid in the cycle after edge k, i.e. one cycle.
- Grant duration: gnt is high for at least 1 and at most HOLD_MAX consecutive cycles.
- Release:
  - req[gnt_idx] sampled low at edge k drops gnt after edge k.
  - The next grant can appear no earlier than after edge k+1, so there is one mandatory idle cycle between grants.
- Timeout pulse coincides with the first IDLE cycle after a forced release.
- Simultaneous release and timeout: if req[gnt_idx] drops in the same cycle the counter hits HOLD_MAX-1, it is a normal release and timeout stays 0.
- Simultaneous requests in IDLE: resolved purely by ptr order, and the decision takes one cycle.
- HOLD_MAX=1: every grant lasts exactly one cycle. It is revoked with timeout=1 unless the requester released in that cycle.

## Test plan
- Single requester: from reset, req=8'h04 held 3 cycles then dropped.
  - gnt=8'h04 and gnt_idx=2 one cycle after the request, lasting 3 cycles.
  - Then 1 idle cycle; timeout never asserted.
- Rotation: from reset, req=8'hFF with each requester dropping its bit one cycle after being granted.
  - Grant order is 0,1,…,7,0, with an idle gap between grants.
  - ptr wraps from 7 to 0.
- Pointer fairness: grant 5 then release; next req=8'h21 (bits 0 and 5).
  - Grant goes to 0 (search starts at 6 and wraps).
  - Next grant goes to 5.
- Timeout: HOLD_MAX=4, req=8'h80 held permanently plus req[1].
  - gnt=8'h80 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0.
  - Next grant is 8'h02.
- Release at the boundary: HOLD_MAX=4, the requester drops req in its 4th grant cycle.
  - Normal release; timeout remains 0.
- Reset mid-grant: rst_n low for 1 cycle during an active grant of index 3.
  - All outputs are 0 the next cycle and ptr=0.
  - With req=8'h09 still high after reset, the first grant goes to 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with bounded grant hold.
// Registered grant index, one-hot grant, valid and forced-revoke pulse.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       any;

  // Walk from the farthest slot back to ptr so the nearest request wins.
  always_comb begin
    pick = ptr;
    cand = ptr;
    any  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick = cand;
        any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold      <= 8'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            state     <= GRANT;
            gnt_idx   <= pick;
            gnt       <= 8'b1 << pick;
            gnt_valid <= 1'b1;
            hold      <= 8'd0;
          end
        end
        GRANT: begin
          if (!req[gnt_idx] || hold == HOLD_LAST) begin
            state     <= IDLE;
            ptr       <= gnt_idx + 3'd1;
            hold      <= 8'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= req[gnt_idx];
          end else begin
            hold <= hold + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors, expected outputs queued per edge
// and checked by an independent monitor one step after each edge.
module tb_rr_arbiter8;

  typedef struct {
    int         id;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  exp_t q[$];
  int   checks;
  int   passed;
  int   vid;
  logic done;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of stimulus and queue what must follow it.
  task automatic v(input logic r, input logic [7:0] rq,
                   input logic [7:0] eg, input logic [2:0] ei,
                   input logic ev, input logic et);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    e.id  = vid;
    e.gnt = eg;
    e.idx = ei;
    e.vld = ev;
    e.to  = et;
    q.push_back(e);
    vid++;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (gnt === e.gnt && gnt_idx === e.idx &&
          gnt_valid === e.vld && timeout === e.to)
        passed++;
      else
        $display("FAIL vec%0d: got gnt=%h idx=%0d vld=%b to=%b want gnt=%h idx=%0d vld=%b to=%b",
                 e.id, gnt, gnt_idx, gnt_valid, timeout,
                 e.gnt, e.idx, e.vld, e.to);
    end
  end

  initial begin
    checks = 0;
    passed = 0;
    vid    = 0;
    done   = 1'b0;
    rst_n  = 1'b0;
    req    = 8'h00;
    // reset
    v(0, 8'h00, 8'h00, 0, 0, 0);
    v(0, 8'h04, 8'h00, 0, 0, 0);
    // single requester, three grant cycles
    v(1, 8'h04, 8'h04, 2, 1, 0);
    v(1, 8'h04, 8'h04, 2, 1, 0);
    v(1, 8'h04, 8'h04, 2, 1, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // rotation from reset
    v(0, 8'h00, 8'h00, 0, 0, 0);
    v(1, 8'hFF, 8'h01, 0, 1, 0);
    v(1, 8'hFE, 8'h00, 0, 0, 0);
    v(1, 8'hFE, 8'h02, 1, 1, 0);
    v(1, 8'hFC, 8'h00, 0, 0, 0);
    v(1, 8'hFC, 8'h04, 2, 1, 0);
    v(1, 8'hF8, 8'h00, 0, 0, 0);
    v(1, 8'hF8, 8'h08, 3, 1, 0);
    v(1, 8'hF0, 8'h00, 0, 0, 0);
    v(1, 8'hF0, 8'h10, 4, 1, 0);
    v(1, 8'hE0, 8'h00, 0, 0, 0);
    v(1, 8'hE0, 8'h20, 5, 1, 0);
    v(1, 8'hC0, 8'h00, 0, 0, 0);
    v(1, 8'hC0, 8'h40, 6, 1, 0);
    v(1, 8'h80, 8'h00, 0, 0, 0);
    v(1, 8'h80, 8'h80, 7, 1, 0);
    v(1, 8'h41, 8'h00, 0, 0, 0);
    v(1, 8'h41, 8'h01, 0, 1, 0);
    v(1, 8'h40, 8'h00, 0, 0, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // pointer fairness, ptr=1
    v(1, 8'h20, 8'h20, 5, 1, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    v(1, 8'h21, 8'h01, 0, 1, 0);
    v(1, 8'h20, 8'h00, 0, 0, 0);
    v(1, 8'h20, 8'h20, 5, 1, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // forced release after four cycles, ptr=6
    v(1, 8'h82, 8'h80, 7, 1, 0);
    v(1, 8'h82, 8'h80, 7, 1, 0);
    v(1, 8'h82, 8'h80, 7, 1, 0);
    v(1, 8'h82, 8'h80, 7, 1, 0);
    v(1, 8'h82, 8'h00, 0, 0, 1);
    v(1, 8'h82, 8'h02, 1, 1, 0);
    v(1, 8'h80, 8'h00, 0, 0, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // release in the last allowed cycle, ptr=2
    v(1, 8'h10, 8'h10, 4, 1, 0);
    v(1, 8'h10, 8'h10, 4, 1, 0);
    v(1, 8'h10, 8'h10, 4, 1, 0);
    v(1, 8'h10, 8'h10, 4, 1, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // reset mid-grant, ptr=5
    v(1, 8'h08, 8'h08, 3, 1, 0);
    v(0, 8'h09, 8'h00, 0, 0, 0);
    v(1, 8'h09, 8'h01, 0, 1, 0);
    v(1, 8'h08, 8'h00, 0, 0, 0);
    v(1, 8'h08, 8'h08, 3, 1, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    // reset during the timeout cycle, ptr=4
    v(1, 8'h40, 8'h40, 6, 1, 0);
    v(1, 8'h40, 8'h40, 6, 1, 0);
    v(1, 8'h40, 8'h40, 6, 1, 0);
    v(1, 8'h40, 8'h40, 6, 1, 0);
    v(1, 8'h40, 8'h00, 0, 0, 1);
    v(0, 8'h40, 8'h00, 0, 0, 0);
    v(1, 8'h00, 8'h00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
